// File: rtl/alu8_pkg.sv
// alu8_pkg: shared opcode/state encodings and combinational evaluator for single-cycle ALU ops
package alu8_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;
  function automatic logic [8:0] alu_eval(op_t op, logic [7:0] a, logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_SHL:  return {a, 1'b0};
      OP_SHR:  return {a[0], 1'b0, a[7:1]};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq8_if.sv
// alu_seq8_if: request (Start/Op/A/B) and result (Y/WE/Busy/Cout/Zero) bundle for alu_seq8
interface alu_seq8_if;
  logic       Start;
  logic [2:0] Op;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Y;
  logic       WE;
  logic       Busy;
  logic       Cout;
  logic       Zero;
  modport master (output Start, Op, A, B, input Y, WE, Busy, Cout, Zero);
  modport slave (input Start, Op, A, B, output Y, WE, Busy, Cout, Zero);
endinterface

// File: rtl/mul8_shift_add.sv
// mul8_shift_add: 8x8 shift-add multiplier, Go loads A/B, 8 iterations, Done flags the last one with P valid
module mul8_shift_add (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        Go,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        Done,
  output logic [15:0] P
);
  logic [15:0] mcand, acc, sum;
  logic [7:0]  mplier;
  logic [3:0]  cnt;
  logic        run;
  always_comb begin
    sum  = acc + (mplier[0] ? mcand : 16'd0);
    Done = run && cnt == 4'd7;
    P    = sum;
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (Go) begin
      mcand  <= {8'd0, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= Done ? 4'd0 : cnt + 4'd1;
      run    <= !Done;
    end
  end
endmodule

// File: rtl/alu_seq8.sv
// alu_seq8: sequential 8-bit ALU (CLK, CLR, bus=slave alu_seq8_if); 1-cycle ops, 8-cycle MUL, registered Y/Cout/Zero with WE pulse
module alu_seq8
  import alu8_pkg::*;
(
  input logic       CLK,
  input logic       CLR,
  alu_seq8_if.slave bus
);
  state_t      state, state_n;
  op_t         op_q;
  logic [7:0]  a_q, b_q, y_q;
  logic        we_q, cout_q, zero_q;
  logic        accept, go, done, load;
  logic [15:0] p;
  logic [8:0]  res;
  mul8_shift_add u_mul (
    .CLK  (CLK),
    .CLR  (CLR),
    .Go   (go),
    .A    (bus.A),
    .B    (bus.B),
    .Done (done),
    .P    (p)
  );
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == S_IDLE ? (bus.Start ? (bus.Op == OP_MUL ? S_MUL : S_EXEC) : S_IDLE)
            : (state == S_MUL && !done) ? S_MUL : S_IDLE;
  end
  always_comb begin
    accept   = state == S_IDLE && bus.Start;
    go       = accept && bus.Op == OP_MUL;
    load     = state == S_EXEC || (state == S_MUL && done);
    res      = state == S_MUL ? {|p[15:8], p[7:0]} : alu_eval(op_q, a_q, b_q);
    bus.Busy = state != S_IDLE;
    bus.Y    = y_q;
    bus.WE   = we_q;
    bus.Cout = cout_q;
    bus.Zero = zero_q;
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
      we_q   <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      if (accept) begin
        op_q <= op_t'(bus.Op);
        a_q  <= bus.A;
        b_q  <= bus.B;
      end
      we_q <= load;
      if (load) begin
        y_q    <= res[7:0];
        cout_q <= res[8];
        zero_q <= res[7:0] == 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq8.sv
// tb_alu_seq8: directed and randomized self-checking bench for alu_seq8 against an arithmetic reference model
module tb_alu_seq8;
  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  alu_seq8_if bus();
  alu_seq8 dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );
  function automatic logic [8:0] model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    int x, y, r, c;
    x = int'(a);
    y = int'(b);
    r = 0;
    c = 0;
    case (op)
      3'd0: begin r = x + y; c = int'(r > 255); end
      3'd1: begin r = x - y; c = int'(x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin r = x * 2; c = int'(x > 127); end
      3'd6: begin r = x / 2; c = x % 2; end
      default: begin r = x * y; c = int'(r > 255); end
    endcase
    r = r & 255;
    return {c[0], r[7:0]};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [8:0] e;
    int n, busyc, lat;
    logic we;
    e = model(op, a, b);
    lat = op == 3'd7 ? 8 : 1;
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Op = 3'($urandom);
    bus.A = 8'($urandom);
    bus.B = 8'($urandom);
    n = 0;
    busyc = 0;
    do begin
      @(negedge clk);
      we = bus.WE;
      if (!we) begin
        busyc += int'(bus.Busy);
        n++;
      end
    end while (!we && n < 20);
    chk({tag, " latency"}, 16'(n), 16'(lat));
    chk({tag, " busy_cycles"}, 16'(busyc), 16'(lat));
    chk({tag, " Y"}, 16'(bus.Y), 16'(e[7:0]));
    chk({tag, " Cout"}, 16'(bus.Cout), 16'(e[8]));
    chk({tag, " Zero"}, 16'(bus.Zero), 16'(e[7:0] == 8'd0));
    @(negedge clk);
    chk({tag, " WE_one_cycle"}, 16'(bus.WE), 16'd0);
    chk({tag, " Y_hold"}, 16'(bus.Y), 16'(e[7:0]));
  endtask
  initial begin
    int wes;
    logic [7:0] yg;
    clr = 1'b1;
    bus.Start = 1'b0;
    bus.Op = 3'd0;
    bus.A = 8'd0;
    bus.B = 8'd0;
    #2;
    chk("reset Y", 16'(bus.Y), 16'd0);
    chk("reset WE", 16'(bus.WE), 16'd0);
    chk("reset Busy", 16'(bus.Busy), 16'd0);
    chk("reset Cout", 16'(bus.Cout), 16'd0);
    chk("reset Zero", 16'(bus.Zero), 16'd1);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("post_reset Busy", 16'(bus.Busy), 16'd0);
    chk("post_reset WE", 16'(bus.WE), 16'd0);
    issue(3'd0, 8'd200, 8'd100, "add_200_100");
    chk("add_200_100 Y44", 16'(bus.Y), 16'd44);
    issue(3'd1, 8'd5, 8'd5, "sub_5_5");
    chk("sub_5_5 Zero1", 16'(bus.Zero), 16'd1);
    issue(3'd1, 8'd3, 8'd4, "sub_3_4");
    chk("sub_3_4 Y255", 16'(bus.Y), 16'd255);
    issue(3'd7, 8'd15, 8'd17, "mul_15_17");
    chk("mul_15_17 Y255", 16'(bus.Y), 16'd255);
    issue(3'd7, 8'd16, 8'd16, "mul_16_16");
    chk("mul_16_16 Cout1", 16'(bus.Cout), 16'd1);
    // back-to-back: new Start in the WE cycle
    bus.Start = 1'b1;
    bus.Op = 3'd4;
    bus.A = 8'hF0;
    bus.B = 8'hFF;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b xor WE", 16'(bus.WE), 16'd1);
    chk("b2b xor Y", 16'(bus.Y), 16'h0F);
    bus.Start = 1'b1;
    bus.Op = 3'd6;
    bus.A = 8'h81;
    bus.B = 8'h00;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("b2b shr busy", 16'(bus.Busy), 16'd1);
    chk("b2b shr WE_low", 16'(bus.WE), 16'd0);
    @(negedge clk);
    chk("b2b shr WE", 16'(bus.WE), 16'd1);
    chk("b2b shr Y", 16'(bus.Y), 16'h40);
    chk("b2b shr Cout", 16'(bus.Cout), 16'd1);
    @(negedge clk);
    // Start while a MUL is busy must be dropped
    bus.Start = 1'b1;
    bus.Op = 3'd7;
    bus.A = 8'd12;
    bus.B = 8'd13;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wes = 0;
    yg = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.Start = 1'b1;
        bus.Op = 3'd0;
        bus.A = 8'd1;
        bus.B = 8'd1;
      end
      if (i == 3) bus.Start = 1'b0;
      if (bus.WE) begin
        wes++;
        yg = bus.Y;
      end
    end
    chk("busy_start we_count", 16'(wes), 16'd1);
    chk("busy_start Y", 16'(yg), 16'd156);
    // CLR during MUL iteration 4
    bus.Start = 1'b1;
    bus.Op = 3'd7;
    bus.A = 8'd7;
    bus.B = 8'd9;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_mul Y", 16'(bus.Y), 16'd0);
    chk("clr_mul Busy", 16'(bus.Busy), 16'd0);
    chk("clr_mul WE", 16'(bus.WE), 16'd0);
    chk("clr_mul Cout", 16'(bus.Cout), 16'd0);
    chk("clr_mul Zero", 16'(bus.Zero), 16'd1);
    @(negedge clk);
    clr = 1'b0;
    wes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.WE) wes++;
    end
    chk("clr_mul no_we", 16'(wes), 16'd0);
    chk("clr_mul Y_after", 16'(bus.Y), 16'd0);
    issue(3'd0, 8'd1, 8'd1, "add_1_1");
    chk("add_1_1 Y2", 16'(bus.Y), 16'd2);
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq8.md
ALU_SEQ8 -- requirements
Module: alu_seq8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and CLR.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 CLR  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  operation request, sampled only in IDLE.
REQ-005 Op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-006 A  input  8  operand A.
REQ-007 B  input  8  operand B (ignored for SHL/SHR).
REQ-008 Y  output  8  registered result; drives the downstream 8-bit register D input.
REQ-009 WE  output  1  one-cycle result-valid pulse; drives the downstream register En.
REQ-010 Busy  output  1  high whenever state is not IDLE.
REQ-011 Cout  output  1  registered carry/borrow/shift-out/overflow flag, updated with Y.
REQ-012 Zero  output  1  registered flag, high when Y == 0, updated with Y.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and MUL; Busy = (state != IDLE).
REQ-014 In IDLE with Start=1 at edge k, A, B and Op SHALL be captured; the next state SHALL be MUL if Op=111, else EXEC.
REQ-015 Start=1 while Busy=1 SHALL be ignored, with no capture and no queuing.
REQ-016 EXEC SHALL, at edge k+1, load Y/Cout/Zero, set WE=1 for exactly that one cycle, and return to IDLE (latency 1 cycle).
REQ-017 ADD: Y = (A+B) mod 256, Cout = bit 8 of the 9-bit sum.
REQ-018 SUB: Y = (A-B) mod 256, Cout = 1 iff A < B (borrow).
REQ-019 AND/OR/XOR: bitwise operation, Cout = 0.
REQ-020 SHL: Y = {A[6:0],0}, Cout = A[7].
REQ-021 SHR: logical shift, Y = {0,A[7:1]}, Cout = A[0].
REQ-022 MUL SHALL use shift-add with a 4-bit iteration counter.
REQ-023 MUL SHALL perform one iteration per edge k+1..k+8 on a 16-bit accumulator.
REQ-024 At edge k+8, MUL SHALL load Y = product[7:0] and Cout = |product[15:8], pulse WE, and return to IDLE.
REQ-025 WE SHALL be 0 in every cycle except the single result cycle.
REQ-026 Y, Cout and Zero SHALL hold their values between results.
REQ-027 Back-to-back: Start=1 in the IDLE cycle in which WE=1 SHALL be accepted, giving a minimum issue interval of 2 cycles for non-MUL ops.
REQ-028 Operand or opcode changes after capture SHALL NOT affect the result in flight.

Reset
REQ-029 While CLR=1, the block SHALL asynchronously force state=IDLE, Y=0, WE=0, Busy=0, Cout=0, Zero=1, counter=0 and accumulator=0.
REQ-030 CLR asserted mid-EXEC or mid-MUL SHALL abort the operation with no WE pulse; the first Start accepted after CLR deasserts SHALL behave normally.

Structure
REQ-031 Opcode constants and FSM state encodings SHALL live in shared package alu8_pkg, to be reused by the future instruction decoder.
REQ-032 The iterative multiplier SHALL be one sub-module, mul8_shift_add, with ports CLK, CLR, Go, A, B, Done and P[15:0]; all other logic stays in alu_seq8.

Verification
REQ-033 The bench SHALL cover all of the following directed scenarios:
- ADD 200+100 -> Y=44, Cout=1, Zero=0, WE high for exactly 1 cycle, 1 cycle after the Start edge.
- SUB 5-5 -> Y=0, Zero=1, Cout=0.
- SUB 3-4 -> Y=255, Cout=1.
- MUL 15*17 -> Y=255, Cout=0, WE 8 cycles after Start, Busy high for 8 cycles.
- MUL 16*16 -> Y=0, Cout=1, Zero=1.
- Start pulsed while a MUL is in progress -> ignored; only one WE pulse occurs.
- Start asserted in the WE cycle (XOR 0xF0^0xFF, then SHR 0x81) -> Y=0x0F, then Y=0x40 with Cout=1 two cycles later.
- CLR pulsed at iteration 4 of MUL 7*9 -> no WE, all outputs at reset values; a subsequent ADD 1+1 -> Y=2.
